// File: rtl/bonus_pkg.sv
// Shared types and constants for the bonus spawn generator.
// Grid geometry, LFSR polynomial and fallback cell live here so producer and bench agree.
package bonus_pkg;

  typedef enum logic [2:0] {
    S_DELAY,
    S_DRAW,
    S_QUERY,
    S_CHECK,
    S_RISE,
    S_HOLD
  } spawn_state_t;

  localparam int          GRID_COLS    = 20;
  localparam int          GRID_ROWS    = 15;
  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam int          FALLBACK_COL = 4;
  localparam int          FALLBACK_ROW = 4;

  // One right-shifting Galois step: the bit shifted out selects the feedback taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value, input logic [15:0] poly);
    return value[0] ? ((value >> 1) ^ poly) : (value >> 1);
  endfunction

  function automatic logic [4:0] sat_inc5(input logic [4:0] value);
    return (value == 5'h1f) ? value : value + 5'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock regardless of game state.
module lfsr16
  import bonus_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter logic [15:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] value
);

  logic [15:0] value_next;

  // A zero state would lock up forever, so it is steered back to the seed.
  always_comb begin
    value_next = lfsr_step(value, POLY);
    if (value_next == 16'h0000) value_next = SEED;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) value <= SEED;
    else         value <= value_next;
  end

endmodule

// File: rtl/bonus_spawn_gen.sv
// Bonus-item cell producer: draws LFSR candidates, filters by grid range and tile map,
// then strobes one accepted cell after a seconds-based delay and holds it until released.
module bonus_spawn_gen
  import bonus_pkg::*;
#(
  parameter int          COLS            = GRID_COLS,
  parameter int          ROWS            = GRID_ROWS,
  parameter int          SPAWN_DELAY_SEC = 5,
  parameter int          LIFETIME_SEC    = 16,
  parameter int          MAX_TRIES       = 16,
  parameter int          FALLBACK_X      = FALLBACK_COL,
  parameter int          FALLBACK_Y      = FALLBACK_ROW,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       gameEn,
  input  logic       one_sec,
  input  logic       newRandom,
  input  logic       mapCellFree,
  output logic [4:0] mapQueryX,
  output logic [3:0] mapQueryY,
  output logic [4:0] randomX,
  output logic [3:0] randomY,
  output logic       randomRise,
  output logic       busy
);

  localparam logic [5:0] COLS_W     = 6'(COLS);
  localparam logic [4:0] ROWS_W     = 5'(ROWS);
  localparam logic [4:0] DELAY_LAST = 5'(SPAWN_DELAY_SEC - 1);
  localparam logic [4:0] LIFE_LAST  = 5'(LIFETIME_SEC - 1);
  localparam logic [4:0] TRIES_MAX  = 5'(MAX_TRIES);
  localparam logic [4:0] FB_X       = 5'(FALLBACK_X);
  localparam logic [3:0] FB_Y       = 4'(FALLBACK_Y);

  logic [15:0]  lfsr;
  logic [4:0]   cand_x;
  logic [3:0]   cand_y;
  logic         cand_in_range;
  logic         lfsr_unused;
  spawn_state_t state_reg;
  logic [4:0]   sec_cnt_reg;
  logic [4:0]   tries_reg;
  logic         rise_reg;
  logic         busy_reg;
  logic         hold_exit;

  lfsr16 #(
    .SEED(LFSR_SEED),
    .POLY(LFSR_POLY)
  ) u_lfsr (
    .clk   (clk),
    .resetN(resetN),
    .value (lfsr)
  );

  assign cand_x        = lfsr[4:0];
  assign cand_y        = lfsr[11:8];
  assign lfsr_unused   = ^{lfsr[15:12], lfsr[7:5]};
  assign cand_in_range = ({1'b0, cand_x} < COLS_W) && ({1'b0, cand_y} < ROWS_W);
  assign hold_exit     = newRandom || (one_sec && (sec_cnt_reg == LIFE_LAST));

  // The strobe is gated so a game stop during S_RISE never leaks a cell downstream.
  assign randomRise = rise_reg & gameEn;
  assign busy       = busy_reg;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg   <= S_DELAY;
      sec_cnt_reg <= 5'd0;
      tries_reg   <= 5'd0;
      randomX     <= FB_X;
      randomY     <= FB_Y;
      mapQueryX   <= 5'd0;
      mapQueryY   <= 4'd0;
      rise_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else if (!gameEn) begin
      state_reg   <= S_DELAY;
      sec_cnt_reg <= 5'd0;
      tries_reg   <= 5'd0;
      rise_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      busy_reg <= 1'b1;
      case (state_reg)
        S_DELAY: begin
          busy_reg <= 1'b0;
          if (one_sec) begin
            if (sec_cnt_reg == DELAY_LAST) begin
              sec_cnt_reg <= 5'd0;
              tries_reg   <= 5'd0;
              busy_reg    <= 1'b1;
              state_reg   <= S_DRAW;
            end else begin
              sec_cnt_reg <= sat_inc5(sec_cnt_reg);
            end
          end
        end
        S_DRAW: begin
          // Retry budget is checked before the candidate, so the fallback is never map-checked.
          if (tries_reg >= TRIES_MAX) begin
            randomX   <= FB_X;
            randomY   <= FB_Y;
            rise_reg  <= 1'b1;
            state_reg <= S_RISE;
          end else if (cand_in_range) begin
            mapQueryX <= cand_x;
            mapQueryY <= cand_y;
            state_reg <= S_QUERY;
          end else begin
            tries_reg <= sat_inc5(tries_reg);
          end
        end
        S_QUERY: state_reg <= S_CHECK;
        S_CHECK: begin
          if (mapCellFree) begin
            randomX   <= mapQueryX;
            randomY   <= mapQueryY;
            rise_reg  <= 1'b1;
            state_reg <= S_RISE;
          end else begin
            tries_reg <= sat_inc5(tries_reg);
            state_reg <= S_DRAW;
          end
        end
        S_RISE: begin
          sec_cnt_reg <= 5'd0;
          state_reg   <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_exit) begin
            sec_cnt_reg <= 5'd0;
            busy_reg    <= 1'b0;
            state_reg   <= S_DELAY;
          end else if (one_sec) begin
            sec_cnt_reg <= sat_inc5(sec_cnt_reg);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_DELAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bonus_spawn_gen.sv
// Randomized self-checking bench for bonus_spawn_gen against a transaction-level spawn model.
module tb_bonus_spawn_gen;

  localparam int          T_COLS  = 20;
  localparam int          T_ROWS  = 15;
  localparam int          T_TRIES = 16;
  localparam int          T_FB_X  = 4;
  localparam int          T_FB_Y  = 4;
  localparam logic [15:0] T_SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetN;
  logic       gameEn;
  logic       one_sec;
  logic       newRandom;
  logic       mapCellFree = 1'b0;
  logic [4:0] mapQueryX;
  logic [3:0] mapQueryY;
  logic [4:0] randomX;
  logic [3:0] randomY;
  logic       randomRise;
  logic       busy;

  int          checks   = 0;
  int          failures = 0;
  int          map_mode = 0;
  bit          occ [0:31][0:15];
  logic [15:0] g_lfsr;
  int          exp_x;
  int          exp_y;

  bonus_spawn_gen dut (
    .clk        (clk),
    .resetN     (resetN),
    .gameEn     (gameEn),
    .one_sec    (one_sec),
    .newRandom  (newRandom),
    .mapCellFree(mapCellFree),
    .mapQueryX  (mapQueryX),
    .mapQueryY  (mapQueryY),
    .randomX    (randomX),
    .randomY    (randomY),
    .randomRise (randomRise),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic bit map_free(input int x, input int y);
    if (map_mode == 0) return 1'b1;
    if (map_mode == 1) return 1'b0;
    return !occ[x][y];
  endfunction

  // Golden LFSR, kept in lockstep with the clock and reset.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) g_lfsr <= T_SEED;
    else         g_lfsr <= ref_step(g_lfsr);
  end

  // Tile map answers whatever cell is currently being queried.
  always @(negedge clk) mapCellFree = map_free(int'(mapQueryX), int'(mapQueryY));

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Walk the spawn rules from the LFSR value seen in the first draw cycle:
  // returns cycles until the strobe and the cell it must carry.
  function automatic void predict(input logic [15:0] l0, output int r, output int x, output int y);
    int          tries = 0;
    int          k = 0;
    int          cx, cy;
    logic [15:0] l = l0;
    r = -1;
    x = 0;
    y = 0;
    while (r < 0) begin
      cx = int'(l[4:0]);
      cy = int'(l[11:8]);
      if (tries >= T_TRIES) begin
        r = k + 1; x = T_FB_X; y = T_FB_Y;
      end else if (cx < T_COLS && cy < T_ROWS) begin
        if (map_free(cx, cy)) begin
          r = k + 3; x = cx; y = cy;
        end else begin
          tries++; k += 3; l = ref_step(ref_step(ref_step(l)));
        end
      end else begin
        tries++; k++; l = ref_step(l);
      end
    end
  endfunction

  function automatic int first_query(input logic [15:0] l0);
    logic [15:0] l = l0;
    for (int q = 0; q < T_TRIES; q++) begin
      if (int'(l[4:0]) < T_COLS && int'(l[11:8]) < T_ROWS) return q;
      l = ref_step(l);
    end
    return -1;
  endfunction

  task automatic randomize_map();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 16; y++)
        occ[x][y] = ($urandom_range(0, 99) < 45);
  endtask

  // Issue n one_sec pulses with random gaps; ends at the negedge driving the last pulse.
  task automatic pulse_delay(input int n, input string tag);
    int gap;
    for (int p = 0; p < n; p++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        one_sec   = 1'b0;
        newRandom = 1'($urandom_range(0, 1));
        check_eq({tag, "_delay_rise"}, int'(randomRise), 0);
      end
      @(negedge clk);
      newRandom = 1'b0;
      check_eq({tag, "_delay_busy"}, int'(busy), 0);
      check_eq({tag, "_delay_x_held"}, int'(randomX), exp_x);
      check_eq({tag, "_delay_y_held"}, int'(randomY), exp_y);
      one_sec = 1'b1;
    end
  endtask

  // Full spawn from S_DELAY with secCnt=0; ends at the negedge where the strobe is visible.
  task automatic run_spawn(input int mode, input string tag);
    int r, px, py;
    map_mode = mode;
    pulse_delay(5, tag);
    predict(ref_step(g_lfsr), r, px, py);
    for (int k = 0; k <= r; k++) begin
      @(negedge clk);
      one_sec = 1'b0;
      check_eq({tag, "_busy"}, int'(busy), 1);
      if (k < r) begin
        check_eq({tag, "_early_rise"}, int'(randomRise), 0);
        check_eq({tag, "_x_stable"}, int'(randomX), exp_x);
      end else begin
        check_eq({tag, "_rise"}, int'(randomRise), 1);
        check_eq({tag, "_x"}, int'(randomX), px);
        check_eq({tag, "_y"}, int'(randomY), py);
      end
    end
    exp_x = px;
    exp_y = py;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int q;
    resetN = 1'b0; gameEn = 1'b1; one_sec = 1'b0; newRandom = 1'b0;
    exp_x = T_FB_X; exp_y = T_FB_Y;
    #12;
    check_eq("rst_x", int'(randomX), T_FB_X);
    check_eq("rst_y", int'(randomY), T_FB_Y);
    check_eq("rst_rise", int'(randomRise), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_qx", int'(mapQueryX), 0);
    check_eq("rst_qy", int'(mapQueryY), 0);
    @(negedge clk);
    resetN = 1'b1;

    // All cells free: first accepted cell, in range, strobe one cycle wide.
    run_spawn(0, "free");
    check_eq("free_range_x", int'(randomX < 5'd20), 1);
    check_eq("free_range_y", int'(randomY < 4'd15), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      one_sec = (i % 2 == 0);
      check_eq("hold_rise_low", int'(randomRise), 0);
      check_eq("hold_busy", int'(busy), 1);
      check_eq("hold_x_held", int'(randomX), exp_x);
    end
    @(negedge clk);
    one_sec = 1'b0;
    newRandom = 1'b1;
    @(negedge clk);
    newRandom = 1'b0;
    check_eq("release_busy", int'(busy), 0);

    // Every cell occupied: fallback after exhausting retries.
    run_spawn(1, "occ");

    // Lifetime expiry on the 16th one_sec pulse.
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      check_eq("life_busy", int'(busy), 1);
      one_sec = 1'b1;
      @(negedge clk);
      one_sec = 1'b0;
      check_eq("life_after_pulse_busy", int'(busy), (p < 15) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      newRandom = 1'b1;
      check_eq("delay_newrandom_busy", int'(busy), 0);
      check_eq("delay_newrandom_rise", int'(randomRise), 0);
    end
    @(negedge clk);
    newRandom = 1'b0;

    // Random occupancy maps.
    for (int i = 0; i < 5; i++) begin
      randomize_map();
      run_spawn(2, "rmap");
      @(negedge clk);
      newRandom = 1'b1;
      @(negedge clk);
      newRandom = 1'b0;
      check_eq("rmap_release_busy", int'(busy), 0);
    end

    // gameEn drop part way through the delay must restart the seconds count.
    map_mode = 0;
    pulse_delay(3, "partial");
    @(negedge clk);
    one_sec = 1'b0;
    gameEn = 1'b0;
    @(negedge clk);
    gameEn = 1'b1;
    check_eq("partial_drop_busy", int'(busy), 0);

    // gameEn drop during the map query: no strobe, back to S_DELAY.
    pulse_delay(5, "qdrop");
    q = first_query(ref_step(g_lfsr));
    target = (q >= 0) ? q + 1 : 0;
    for (int k = 0; k <= target; k++) begin
      @(negedge clk);
      one_sec = 1'b0;
      check_eq("qdrop_busy", int'(busy), 1);
      check_eq("qdrop_rise", int'(randomRise), 0);
    end
    gameEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      one_sec = 1'($urandom_range(0, 1));
      check_eq("gamedis_rise", int'(randomRise), 0);
      check_eq("gamedis_busy", int'(busy), 0);
      check_eq("gamedis_x_held", int'(randomX), exp_x);
    end
    @(negedge clk);
    one_sec = 1'b0;
    gameEn = 1'b1;
    run_spawn(0, "after_drop");

    // Asynchronous reset while holding a cell, then LFSR restart from the seed.
    @(negedge clk);
    check_eq("prerst_busy", int'(busy), 1);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("arst_x", int'(randomX), T_FB_X);
    check_eq("arst_y", int'(randomY), T_FB_Y);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_rise", int'(randomRise), 0);
    check_eq("arst_qx", int'(mapQueryX), 0);
    exp_x = T_FB_X;
    exp_y = T_FB_Y;
    @(negedge clk);
    resetN = 1'b1;
    run_spawn(0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bonus_spawn_gen.md
Name: bonus_spawn_gen

Overview:
- Upstream producer for the bonus-item placement checker.
- Generates pseudo-random grid cells (column 0..COLS-1, row 0..ROWS-1) from a free-running LFSR.
- Rejects out-of-range cells and cells the tile map reports as occupied.
- Presents one accepted cell with a single-cycle randomRise strobe after a seconds-based spawn delay, then waits for the consumer to release it before scheduling the next one.

Parameters:
- COLS, 20, number of grid columns; valid X is 0..COLS-1, COLS<=32.
- ROWS, 15, number of grid rows; valid Y is 0..ROWS-1, ROWS<=16.
- SPAWN_DELAY_SEC, 5, one_sec pulses counted before each draw attempt begins.
- LIFETIME_SEC, 16, one_sec pulses in S_HOLD before a forced re-arm.
- MAX_TRIES, 16, rejected candidates allowed before the fallback cell is used.
- FALLBACK_X, 4, fallback column.
- FALLBACK_Y, 4, fallback row.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- gameEn  in  1  game running; low forces re-arm.
- one_sec  in  1  single-cycle pulse once per second.
- newRandom  in  1  consumer request to release the current cell and schedule the next.
- mapCellFree  in  1  tile-map answer for mapQueryX/Y, valid one cycle after the query is driven.
- mapQueryX  out  5  candidate column presented to the tile map.
- mapQueryY  out  4  candidate row presented to the tile map.
- randomX  out  5  accepted column.
- randomY  out  4  accepted row.
- randomRise  out  1  one-cycle strobe: randomX/Y hold a new cell.
- busy  out  1  high in every state except S_DELAY.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on resetN.
- Reset values:
  - lfsr=LFSR_SEED, state=S_DELAY, secCnt=0, tries=0.
  - randomX=FALLBACK_X, randomY=FALLBACK_Y, mapQueryX=0, mapQueryY=0.
  - randomRise=0, busy=0.
- LFSR:
  - 16-bit Galois, polynomial 0xB400.
  - Shifts every clk cycle regardless of state or gameEn.
  - Never loads zero.
- Candidate: candX=lfsr[4:0], candY=lfsr[11:8]. Range is checked by comparison; no modulo.
- FSM (all transitions registered):
  - S_DELAY: secCnt increments on one_sec. At secCnt==SPAWN_DELAY_SEC-1 with one_sec high: clear secCnt and tries, go to S_DRAW.
  - S_DRAW:
    - If candX<COLS and candY<ROWS: latch candidate into mapQueryX/Y, go to S_QUERY.
    - Otherwise: tries++, stay in S_DRAW.
  - S_QUERY: one wait cycle for the map read, go to S_CHECK.
  - S_CHECK:
    - mapCellFree=1: randomX/Y<=mapQueryX/Y, go to S_RISE.
    - mapCellFree=0: tries++, go to S_DRAW.
  - Fallback: in S_DRAW or S_CHECK, if tries reaches MAX_TRIES, load FALLBACK_X/Y into randomX/Y and go to S_RISE. The fallback cell is not map-checked.
  - S_RISE: randomRise=1 for exactly this cycle. Clear secCnt, go to S_HOLD.
  - S_HOLD:
    - randomX/Y held stable.
    - secCnt increments on one_sec.
    - Exit to S_DELAY, secCnt<=0, on newRandom=1 or on secCnt==LIFETIME_SEC-1 with one_sec high.
- Latency: S_DRAW to randomRise is at least 3 cycles for an immediately accepted cell. The worst case is bounded by the retry count plus range rejections. Each range-rejected cycle counts as one try, so the total is at most MAX_TRIES failures.
- Counter and output widths: tries is 5 bits and secCnt is 5 bits; both saturate and never wrap. randomX/Y change only on entry to S_RISE.
- Boundary conditions:
  - newRandom outside S_HOLD is ignored.
  - one_sec and newRandom in the same S_HOLD cycle: exit; secCnt<=0.
  - gameEn=0 in any state: next state S_DELAY, secCnt=0, tries=0, randomRise=0. randomX/Y retain their last value.
  - gameEn deasserted in S_RISE: randomRise is suppressed that cycle.
  - resetN low mid-operation: all state returns to reset values immediately (asynchronous).
  - The map answer is sampled only in S_CHECK.

Decomposition:
- Shared package (bonus_pkg): state enum {S_DELAY,S_DRAW,S_QUERY,S_CHECK,S_RISE,S_HOLD}, GRID_COLS=20, GRID_ROWS=15, LFSR_POLY=16'hB400, fallback cell constants.
- One sub-module, lfsr16: parameters seed and poly; output current value; free-running.

Test Plan:
- Reset, hold gameEn=1, mapCellFree=1, pulse one_sec 5 times -> first randomRise 3..(3+MAX_TRIES) cycles after the 5th pulse; randomX<20, randomY<15; randomRise exactly 1 cycle wide.
- Tie mapCellFree=0 -> after 16 tries, randomRise with randomX=4, randomY=4.
- After a rise, pulse newRandom once -> busy drops next cycle; next randomRise only after 5 more one_sec pulses; randomX/Y unchanged until then.
- After a rise, no newRandom, pulse one_sec 16 times -> return to S_DELAY on the 16th; newRandom while in S_DELAY has no effect.
- Drop gameEn in S_QUERY -> no randomRise; state S_DELAY; secCnt restarts from 0 after gameEn returns.
- Assert resetN low during S_HOLD -> randomX=4, randomY=4, busy=0, randomRise=0 immediately without a clock edge; LFSR restarts at 16'hACE1 (sequence matches a golden model).
